// File: rtl/fab_pkg.sv
// Shared definitions for the factory station timing blocks: timer FSM states,
// default counter geometry and the 100 ms tick period.
package fab_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StOn,
    StDone
  } timer_state_e;

  localparam int unsigned DefCntW    = 13;
  localparam int unsigned DefOnTicks = 500;

  // Clock cycles per pulse100ms strobe, assuming a 100 MHz system clock.
  localparam int unsigned Pulse100msPeriod = 10_000_000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr_i,
// wrapping modulo N. Output is one-hot, or all-zero when nobody requests.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o
);

  always_comb begin
    logic            found;
    logic [IdxW-1:0] idx;
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IdxW'((32'(ptr_i) + k) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/station_timer_scheduler.sv
// Shares one delay-then-on timer between N_REQ stations under round-robin arbitration.
// Define STATION_TIMER_ABORT_EN to let the owner cancel by dropping its request.
module station_timer_scheduler
  import fab_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned CNT_W    = DefCntW,
  parameter int unsigned ON_TICKS = DefOnTicks
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pulse100ms,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] delay_cfg,
  output logic [N_REQ-1:0]       grant,
  output logic                   on_phase,
  output logic                   busy,
  output logic [N_REQ-1:0]       done
);

  localparam int unsigned     IdxW   = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] OnLoad = CNT_W'(ON_TICKS);

  timer_state_e     state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             on_q, on_d;
  logic [IdxW-1:0]  ptr_q, ptr_d;
  logic [IdxW-1:0]  win_q, win_d;

  logic [N_REQ-1:0] arb_gnt;
  logic [IdxW-1:0]  arb_idx;
  logic [CNT_W-1:0] dly_arr [N_REQ];
  logic             req_lost;

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr_arbiter (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt)
  );

  for (genvar g = 0; g < N_REQ; g++) begin : g_dly
    assign dly_arr[g] = delay_cfg[g*CNT_W +: CNT_W];
  end

  always_comb begin
    arb_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (arb_gnt[IdxW'(i)]) arb_idx = IdxW'(i);
    end
  end

`ifdef STATION_TIMER_ABORT_EN
  assign req_lost = ~|(req & grant_q);
`else
  assign req_lost = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    on_d    = on_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    done_d  = '0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          grant_d = arb_gnt;
          win_d   = arb_idx;
          cnt_d   = dly_arr[arb_idx];
          state_d = StDelay;
        end
      end
      StDelay: begin
        // Zero test on the registered count: a tick landing on zero is dropped.
        if (req_lost) begin
          state_d = StDone;
        end else if (cnt_q == '0) begin
          cnt_d   = OnLoad;
          on_d    = 1'b1;
          state_d = StOn;
        end else if (pulse100ms) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StOn: begin
        if (req_lost) begin
          on_d    = 1'b0;
          state_d = StDone;
        end else if (cnt_q == '0) begin
          on_d    = 1'b0;
          done_d  = grant_q;
          state_d = StDone;
        end else if (pulse100ms) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StDone: begin
        grant_d = '0;
        ptr_d   = (win_q == IdxW'(N_REQ - 1)) ? '0 : win_q + IdxW'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      done_q  <= '0;
      cnt_q   <= '0;
      on_q    <= 1'b0;
      ptr_q   <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      on_q    <= on_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
    end
  end

  assign grant    = grant_q;
  assign on_phase = on_q;
  assign busy     = |grant_q;
  assign done     = done_q;

endmodule

// File: tb/tb_station_timer_scheduler.sv
// Self-checking bench for station_timer_scheduler: directed table rows, hand sequences
// and a randomized run against a cycle-level reference model.
module tb_station_timer_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 13;
  localparam int unsigned ON = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           pulse100ms = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] delay_cfg = '0;
  logic [N-1:0]   grant;
  logic           on_phase;
  logic           busy;
  logic [N-1:0]   done;

  int n_checks = 0;
  int n_errors = 0;
  int tick_mode = 0;
  int tick_c = 0;
  bit chk_en = 1'b0;

  station_timer_scheduler #(
    .N_REQ    (N),
    .CNT_W    (W),
    .ON_TICKS (ON)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pulse100ms (pulse100ms),
    .req        (req),
    .delay_cfg  (delay_cfg),
    .grant      (grant),
    .on_phase   (on_phase),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Tick source: 0 off, 1 every 10 cycles, 2 random (about 1 in 4 cycles).
  initial begin
    forever begin
      @(posedge clk);
      #2;
      tick_c++;
      case (tick_mode)
        1:       pulse100ms = (tick_c % 10 == 0);
        2:       pulse100ms = ($urandom_range(3) == 0);
        default: pulse100ms = 1'b0;
      endcase
    end
  end

  // Reference model: owner index (-1 = idle), remaining ticks of the current phase.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;
  bit m_on    = 1'b0;
  bit m_fin   = 1'b0;
  bit m_donep = 1'b0;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < int'(N); k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1;
      m_ptr   <= 0;
      m_cnt   <= 0;
      m_on    <= 1'b0;
      m_fin   <= 1'b0;
      m_donep <= 1'b0;
    end else if (m_fin) begin
      m_ptr   <= (m_owner + 1) % N;
      m_owner <= -1;
      m_fin   <= 1'b0;
      m_donep <= 1'b0;
    end else if (m_owner < 0) begin
      if (req != '0) begin
        m_owner <= pick(req, m_ptr);
        m_cnt   <= int'(delay_cfg[pick(req, m_ptr)*W +: W]);
      end
    end else begin
`ifdef STATION_TIMER_ABORT_EN
      if (!req[m_owner]) begin
        m_fin <= 1'b1;
        m_on  <= 1'b0;
      end else
`endif
      if (m_cnt == 0) begin
        if (!m_on) begin
          m_on  <= 1'b1;
          m_cnt <= ON;
        end else begin
          m_on    <= 1'b0;
          m_fin   <= 1'b1;
          m_donep <= 1'b1;
        end
      end else if (pulse100ms) begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_grant", 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      check("model_on_phase", 32'(on_phase), 32'(m_on));
      check("model_busy", 32'(busy), 32'(m_owner >= 0));
      check("model_done", 32'(done), (m_donep && m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all_delays(input int d);
    for (int i = 0; i < int'(N); i++) delay_cfg[i*W +: W] = W'(d);
  endtask

  task automatic do_reset();
    req = '0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  typedef struct {
    logic [N-1:0] req;
    int           dly;
    logic [N-1:0] gnt;
    bit           chg;
  } row_t;

  row_t rows[6];

  task automatic run_row(input row_t r);
    int  dly_ticks, on_ticks, cyc, rise_cyc;
    bit  risen, done_seen;
    do_reset();
    tick_mode = 1;
    set_all_delays(r.dly);
    req = r.req;
    step();
    check("row_grant", 32'(grant), 32'(r.gnt));
    check("row_busy", 32'(busy), 32'd1);
    if (r.chg) set_all_delays(1);
    dly_ticks = 0; on_ticks = 0; cyc = 0; rise_cyc = -1; risen = 0; done_seen = 0;
    while (!done_seen && cyc < 400) begin
      step();
      cyc++;
      if (!risen) begin
        if (on_phase) begin
          risen = 1;
          rise_cyc = cyc;
        end else if (pulse100ms) begin
          dly_ticks++;
        end
      end else if (on_phase && pulse100ms) begin
        on_ticks++;
      end
      if (done != '0) begin
        done_seen = 1;
        check("row_done", 32'(done), 32'(r.gnt));
        check("row_on_low_at_done", 32'(on_phase), 32'd0);
      end
    end
    if (!done_seen) timeout("row_done_wait");
    check("row_delay_ticks", 32'(dly_ticks), 32'(r.dly));
    check("row_on_ticks", 32'(on_ticks), 32'(ON));
    if (r.dly == 0) check("row_zero_delay_rise", 32'(rise_cyc), 32'd1);
    step();
    check("row_done_one_cycle", 32'(done), 32'd0);
    check("row_grant_fall", 32'(grant), 32'd0);
    req = '0;
  endtask

  initial begin
    logic [N-1:0] exp_seq [5];
    int           waited;
    bit           saw_done;

    rows[0] = '{req: 4'b0001, dly: 2, gnt: 4'b0001, chg: 1'b0};
    rows[1] = '{req: 4'b0100, dly: 0, gnt: 4'b0100, chg: 1'b0};
    rows[2] = '{req: 4'b1010, dly: 1, gnt: 4'b0010, chg: 1'b0};
    rows[3] = '{req: 4'b1000, dly: 3, gnt: 4'b1000, chg: 1'b0};
    rows[4] = '{req: 4'b1100, dly: 1, gnt: 4'b0100, chg: 1'b0};
    rows[5] = '{req: 4'b0010, dly: 5, gnt: 4'b0010, chg: 1'b1};

    rst_n = 1'b0;
    #1;
    chk_en = 1'b1;
    step();
    rst_n = 1'b1;
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_on_phase", 32'(on_phase), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);

    foreach (rows[i]) run_row(rows[i]);

    // Round robin with everybody requesting continuously.
    do_reset();
    set_all_delays(1);
    tick_mode = 1;
    req = 4'b1111;
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      waited = 0;
      while (grant == '0 && waited < 50) begin step(); waited++; end
      if (grant == '0) timeout("rr_grant_wait");
      check("rr_grant", 32'(grant), 32'(exp_seq[i]));
      waited = 0;
      while (done == '0 && waited < 200) begin step(); waited++; end
      if (done == '0) timeout("rr_done_wait");
      check("rr_done", 32'(done), 32'(exp_seq[i]));
      step();
      check("rr_gap", 32'(grant), 32'd0);
    end
    req = '0;

    // Reset while the on-phase runs.
    do_reset();
    set_all_delays(1);
    tick_mode = 1;
    req = 4'b0001;
    waited = 0;
    while (!on_phase && waited < 100) begin step(); waited++; end
    if (!on_phase) timeout("rst_on_wait");
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_grant", 32'(grant), 32'd0);
    check("rst_mid_on", 32'(on_phase), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    req = 4'b0010;
    #2;
    rst_n = 1'b1;
    step();
    check("rst_regrant", 32'(grant), 32'h2);
    req = '0;

`ifdef STATION_TIMER_ABORT_EN
    do_reset();
    set_all_delays(5);
    tick_mode = 1;
    req = 4'b0011;
    step();
    check("abort_grant", 32'(grant), 32'h1);
    repeat (3) step();
    req[0] = 1'b0;
    saw_done = 1'b0;
    repeat (2) begin
      step();
      if (done != '0) saw_done = 1'b1;
    end
    check("abort_grant_clear", 32'(grant), 32'd0);
    check("abort_no_done", 32'(saw_done), 32'd0);
    step();
    check("abort_next_grant", 32'(grant), 32'h2);
    req = '0;
`endif

    // Randomized run: requests held until done, delays churn, random ticks.
    do_reset();
    tick_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!req[i]) begin
          if ($urandom_range(7) == 0) req[i] = 1'b1;
        end else if (done[i]) begin
          if ($urandom_range(1) == 0) req[i] = 1'b0;
        end
`ifdef STATION_TIMER_ABORT_EN
        else if (grant[i] && $urandom_range(63) == 0) begin
          req[i] = 1'b0;
        end
`endif
      end
      delay_cfg[$urandom_range(N-1)*W +: W] = W'($urandom_range(3));
      step();
    end
    req = '0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/station_timer_scheduler.md
# station_timer_scheduler

Shares one delay-then-on timer between up to N_REQ factory stations. Stations raise `req`. A round-robin arbiter grants one station at a time. For the granted station, the block counts that station's programmed delay in `pulse100ms` ticks, then asserts `on_phase` for ON_TICKS ticks, then pulses `done` for that station. It sits between the station control logic and the shared 100 ms tick generator, and it replaces per-station timer instances.

## Interface
- N_REQ, 4, number of requesting stations (2..8)
- CNT_W, 13, width of delay and on-time counters
- ON_TICKS, 500, length of the on-phase in pulse100ms ticks; must be < 2^CNT_W
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous assert, active-low
- pulse100ms  input  1  one-cycle tick strobe, time base for all counting
- req  input  N_REQ  per-station request; level, held until `done` is seen
- delay_cfg  input  N_REQ*CNT_W  per-station delay in ticks; slice i = bits [i*CNT_W +: CNT_W]
- grant  output  N_REQ  one-hot owner of the timer; all-zero when idle
- on_phase  output  1  high while the granted station's on-phase runs
- busy  output  1  high whenever `grant` is non-zero
- done  output  N_REQ  one-cycle one-hot completion strobe

## Operation
- Reset values:
  - grant=0, on_phase=0, busy=0, done=0
  - state=IDLE, counter=0
  - round-robin pointer = station 0 has highest priority
- States:
  - IDLE
    - If any `req` bit is set, select the first requester at or after the pointer, wrapping modulo N_REQ.
    - Register the winner in `grant`.
    - Load counter with delay_cfg[winner] and go to DELAY.
  - DELAY
    - Each `pulse100ms` decrements the counter.
    - When counter==0, load ON_TICKS, set on_phase=1 and go to ON.
    - The zero check uses the registered counter value, so a delay of D gives exactly D ticks.
    - D=0 enters ON one cycle after the grant.
  - ON
    - Each `pulse100ms` decrements the counter.
    - When counter==0, clear on_phase, pulse done[winner] and go to DONE.
  - DONE
    - Lasts one cycle.
    - Clear grant, move the pointer to winner+1 (mod N_REQ) and return to IDLE.
- Counter arithmetic:
  - unsigned CNT_W bits
  - never decrements below 0; a tick arriving at counter==0 is ignored
- `delay_cfg` is sampled only at the grant. Changes during DELAY or ON have no effect.
- `req` changes while granted are ignored, except as described under Configuration.
- A new request arriving while busy waits. No preemption.
- A station that keeps `req` high after its `done` competes again at the lowest priority. This guarantees no starvation.

## Timing
- Grant latency:
  - `grant` rises on the cycle after `req` is sampled in IDLE.
  - Worst-case wait = (N_REQ-1) full service windows + 2 cycles.
- A `pulse100ms` in the same cycle as the grant is not counted.
- on_phase:
  - rises on the cycle after the registered counter reads 0 in DELAY
  - lasts ON_TICKS ticks plus at most one cycle
- `done` is high for exactly one cycle, coincident with the first cycle of DONE.
- `grant` falls on the cycle after `done`.
- Minimum gap between two grants is 2 cycles (DONE, then IDLE).
- Reset mid-operation returns every output to its reset value immediately. The pointer returns to 0.

## Configuration
- STATION_TIMER_ABORT_EN defined:
  - If the granted station drops `req` during DELAY or ON, the block goes to DONE on the next cycle.
  - on_phase drops with it.
  - done[winner] is NOT pulsed.
  - The pointer advances as for normal completion.
- Not defined: `req` is ignored while granted and every grant runs to completion.

## Structure
- The shared package `fab_pkg` holds:
  - the state enum (IDLE, DELAY, ON, DONE)
  - the default CNT_W and ON_TICKS constants
  - the pulse-period constant also used by the tick generator
- One sub-module: `rr_arbiter`, parameterised by N. Inputs are req and pointer; output is a one-hot winner. It is purely combinational and the scheduler registers its output.

## Test plan
- N_REQ=4, ON_TICKS=3; req=0001, delay_cfg[0]=2, tick every 10 cycles:
  - grant=0001 one cycle later
  - on_phase after the 2nd tick, high for 3 ticks
  - done=0001 for one cycle, then grant=0
- req=1111 held high with all delays 1:
  - grants in order 0001, 0010, 0100, 1000, then 0001 again
  - each grant followed by exactly one done for that station
- delay_cfg[2]=0, req=0100: on_phase rises one cycle after the grant with no tick needed.
- Change delay_cfg[1] from 5 to 1 during DELAY: station 1 still waits 5 ticks.
- Assert rst_n=0 mid-ON: grant, on_phase, busy and done go to 0 immediately. After release, req=0010 is granted first (pointer at 0; only station 1 is requesting).
- With STATION_TIMER_ABORT_EN, drop req[0] during DELAY:
  - grant clears within 2 cycles
  - no done pulse
  - the next requester, station 1, is granted
